ram_matrix_reader: RTL and testbench
====================================

// Module: ram_matrix_reader
// PURPOSE
//  Streams a matrix tile out of one port of the dual-port byte-addressed RAM.
//  Reads MASK_WIDTH*DWIDTH-bit words row by row, with a programmable row stride in bytes.
//  Delivers the words to the downstream systolic/feeder stage over a valid/ready stream.
//  Holds an internal FIFO that absorbs the 1-cycle RAM read latency, so backpressure never loses data.
// PARAMETERS
//  AWIDTH      10  RAM byte-address width
//  DWIDTH      8   bits per byte lane
//  MASK_WIDTH  4   byte lanes per word (address step per word = MASK_WIDTH)
//  CNT_WIDTH   8   width of the row and word counters
//  FIFO_DEPTH  4   output FIFO entries (power of 2, >= 4)
// PORTS
//  clk            in   1                  clock
//  resetn         in   1                  asynchronous active-low reset
//  start          in   1                  begin a transfer (sampled only in IDLE)
//  base_addr      in   AWIDTH             byte address of word 0, row 0
//  words_per_row  in   CNT_WIDTH          words per row
//  num_rows       in   CNT_WIDTH          rows in the tile
//  row_stride     in   AWIDTH             byte distance between row starts
//  busy           out  1                  transfer in progress
//  done           out  1                  one-cycle pulse when the transfer completes
//  ram_addr       out  AWIDTH             RAM port address (registered)
//  ram_we         out  MASK_WIDTH         RAM write enables, tied to 0
//  ram_d          out  MASK_WIDTH*DWIDTH  RAM write data, tied to 0
//  ram_q          in   MASK_WIDTH*DWIDTH  RAM read data, valid 1 cycle after the address
//  out_data       out  MASK_WIDTH*DWIDTH  stream data (FIFO head)
//  out_valid      out  1                  stream valid
//  out_ready      in   1                  stream ready
//  out_row_last   out  1                  out_data is the last word of its row
//  out_last       out  1                  out_data is the last word of the tile
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - FSM goes to IDLE; the FIFO, counters and in-flight tracking are cleared.
//   - All outputs read 0. Reset in mid-transfer abandons the transfer with no done pulse.
//  FSM IDLE -> READ -> DRAIN -> IDLE:
//   - IDLE & start: latch all config inputs.
//     - If words_per_row==0 or num_rows==0: pulse done on the next cycle and stay in IDLE.
//     - Otherwise go to READ with busy=1.
//   - READ: issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH.
//     - inflight = reads issued but not yet written to the FIFO (0..2).
//     - An issue presents ram_addr this cycle; ram_q is captured into the FIFO at the end of the next cycle.
//     - Go to DRAIN after the final address is issued.
//   - DRAIN: wait until inflight==0, the FIFO is empty and the last word has handshaked.
//     - Then assert done for 1 cycle, drop busy and return to IDLE.
//  Addressing:
//   - Word w of row r reads base + r*row_stride + w*MASK_WIDTH.
//   - The row-start register is incremented by row_stride; there is no multiplier.
//   - All address sums are taken modulo 2^AWIDTH (wrap silently).
//  Stream:
//   - A word transfers when out_valid & out_ready.
//   - out_data, out_row_last and out_last stay stable while out_valid=1 and out_ready=0.
//   - Tags are generated at issue time and stored in the FIFO with the data.
//  Latency: if start is sampled at edge E0, ram_addr=base during cycle E0..E1 and out_valid=1 after E2.
//  Throughput: with out_ready held at 1, one word per cycle with no bubbles, including across row boundaries.
//  Simultaneous events:
//   - A FIFO push and pop in the same cycle leave fifo_count unchanged.
//   - A pop frees a credit that can be used for an issue in the next cycle.
//   - start is ignored while busy=1.
// TESTING
//  1. base=0x10, wpr=2, rows=2, stride=0x20, ready=1 -> addrs 0x10,0x14,0x30,0x34.
//     Four back-to-back beats, row_last on beats 2 and 4, last on beat 4, done 1 cycle later.
//  2. Same tile with ready low for 6 cycles after the first valid -> issues stop at 4 outstanding.
//     Data is held stable, no word is lost or duplicated, and the order is preserved.
//  3. base=0x3F8 (AWIDTH=10), wpr=4, rows=1 -> addrs 0x3F8,0x3FC,0x000,0x004.
//  4. rows=0 -> done pulses on the next cycle, out_valid stays 0 and ram_addr is never stepped.
//  5. Pulse resetn low mid-READ -> outputs read 0 immediately.
//     A new start afterwards runs a clean transfer; start pulsed while busy has no effect.

Source files
------------

// File: rtl/ram_matrix_reader.sv
// ram_matrix_reader: streams a strided matrix tile out of one RAM port over valid/ready,
// with an output FIFO sized by credits so the 2-cycle read pipeline never overflows it.
module ram_matrix_reader #(
    parameter int AWIDTH     = 10,
    parameter int DWIDTH     = 8,
    parameter int MASK_WIDTH = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [AWIDTH-1:0]            base_addr,
    input  logic [CNT_WIDTH-1:0]         words_per_row,
    input  logic [CNT_WIDTH-1:0]         num_rows,
    input  logic [AWIDTH-1:0]            row_stride,
    output logic                         busy,
    output logic                         done,
    output logic [AWIDTH-1:0]            ram_addr,
    output logic [MASK_WIDTH-1:0]        ram_we,
    output logic [MASK_WIDTH*DWIDTH-1:0] ram_d,
    input  logic [MASK_WIDTH*DWIDTH-1:0] ram_q,
    output logic [MASK_WIDTH*DWIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_row_last,
    output logic                         out_last
);
    localparam int WW = MASK_WIDTH * DWIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AWIDTH-1:0] STEP = AWIDTH'(MASK_WIDTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 done_q, done_d;
    logic [AWIDTH-1:0]    addr_q, addr_d, row_q, row_d, ram_addr_q, ram_addr_d, stride_q;
    logic [CNT_WIDTH-1:0] w_q, w_d, r_q, r_d, wpr_q, rows_q;
    logic                 v1_q, v2_q;
    logic [1:0]           t1_q, t2_q;
    logic [WW+1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wp_q, rp_q;
    logic [CW-1:0]        cnt_q;

    logic                 idle, empty_cfg, credit, issue, row_last, last, push, pop, fin;
    logic [AWIDTH-1:0]    cur_addr, cur_row, cur_stride, next_row;
    logic [CNT_WIDTH-1:0] cur_w, cur_r, cur_wpr, cur_rows;
    logic [WW+1:0]        head;

    // In IDLE the first issue is taken straight from the config inputs.
    assign idle       = state_q == IDLE;
    assign cur_addr   = idle ? base_addr : addr_q;
    assign cur_row    = idle ? base_addr : row_q;
    assign cur_stride = idle ? row_stride : stride_q;
    assign cur_w      = idle ? '0 : w_q;
    assign cur_r      = idle ? '0 : r_q;
    assign cur_wpr    = idle ? words_per_row : wpr_q;
    assign cur_rows   = idle ? num_rows : rows_q;
    assign next_row   = cur_row + cur_stride;
    assign empty_cfg  = words_per_row == '0 || num_rows == '0;
    assign credit     = (cnt_q + CW'(v1_q) + CW'(v2_q)) < CW'(FIFO_DEPTH);
    assign issue      = idle ? (start && !empty_cfg) : (state_q == READ && credit);
    assign row_last   = cur_w == cur_wpr - CNT_WIDTH'(1);
    assign last       = row_last && cur_r == cur_rows - CNT_WIDTH'(1);
    assign push       = v2_q;
    assign pop        = out_valid && out_ready;
    assign fin        = !v1_q && !v2_q && (cnt_q == '0 || (cnt_q == CW'(1) && pop));

    always_comb begin
        state_d    = state_q;
        done_d     = idle && start && empty_cfg;
        addr_d     = addr_q;
        row_d      = row_q;
        w_d        = w_q;
        r_d        = r_q;
        ram_addr_d = ram_addr_q;
        if (issue) begin
            ram_addr_d = cur_addr;
            addr_d     = row_last ? next_row : cur_addr + STEP;
            row_d      = row_last ? next_row : cur_row;
            w_d        = row_last ? '0 : cur_w + CNT_WIDTH'(1);
            r_d        = row_last ? cur_r + CNT_WIDTH'(1) : cur_r;
            state_d    = last ? DRAIN : READ;
        end
        if (state_q == DRAIN && fin) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            addr_q     <= '0;
            row_q      <= '0;
            w_q        <= '0;
            r_q        <= '0;
            ram_addr_q <= '0;
            wpr_q      <= '0;
            rows_q     <= '0;
            stride_q   <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            t1_q       <= '0;
            t2_q       <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            row_q      <= row_d;
            w_q        <= w_d;
            r_q        <= r_d;
            ram_addr_q <= ram_addr_d;
            if (idle && start) begin
                wpr_q    <= words_per_row;
                rows_q   <= num_rows;
                stride_q <= row_stride;
            end
            v1_q  <= issue;
            v2_q  <= v1_q;
            t1_q  <= issue ? {last, row_last} : '0;
            t2_q  <= t1_q;
            wp_q  <= push ? wp_q + PW'(1) : wp_q;
            rp_q  <= pop ? rp_q + PW'(1) : rp_q;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {t2_q, ram_q};
    end

    assign head         = mem_q[rp_q];
    assign out_valid    = cnt_q != '0;
    assign out_data     = out_valid ? head[WW-1:0] : '0;
    assign out_row_last = out_valid && head[WW];
    assign out_last     = out_valid && head[WW+1];
    assign busy         = !idle;
    assign done         = done_q;
    assign ram_addr     = ram_addr_q;
    assign ram_we       = '0;
    assign ram_d        = '0;
endmodule

// File: tb/tb_ram_matrix_reader.sv
// tb_ram_matrix_reader: table-driven tiles plus backpressure/reset sequences, with a
// scoreboard of expected beats built from base + r*stride + w*4 and checked per handshake.
module tb_ram_matrix_reader;
    logic        clk = 1'b0;
    logic        resetn, start, out_ready;
    logic [9:0]  base_addr, row_stride, ram_addr;
    logic [7:0]  words_per_row, num_rows;
    logic        busy, done, out_valid, out_row_last, out_last;
    logic [3:0]  ram_we;
    logic [31:0] ram_d, ram_q, out_data;

    typedef struct {
        logic [31:0] d;
        logic        rl;
        logic        l;
    } beat_t;

    typedef struct {
        logic [9:0] base;
        logic [7:0] wpr;
        logic [7:0] rows;
        logic [9:0] stride;
        int         exp_done;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[7];
    int    checks = 0;
    int    errors = 0;

    ram_matrix_reader dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .words_per_row(words_per_row), .num_rows(num_rows), .row_stride(row_stride),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d),
        .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row_last(out_row_last), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [9:0] a);
        return {a[7:0] ^ 8'hA5, 6'd0, a, 8'h3C ^ a[9:2]};
    endfunction

    always @(posedge clk) ram_q <= word_of(ram_addr);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Handshake monitor: sampled mid-cycle, inputs only change just after posedge.
    initial begin
        logic        pv = 1'b0, pr = 1'b0;
        logic [33:0] pd = '0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!resetn) pv = 1'b0;
            else begin
                if (pv && !pr) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", {out_last, out_row_last, out_data}, pd);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("unexpected_beat", out_valid, 0);
                    else begin
                        e = sb.pop_front();
                        chk("beat_data", out_data, e.d);
                        chk("beat_row_last", out_row_last, e.rl);
                        chk("beat_last", out_last, e.l);
                    end
                end
                pv = out_valid;
                pr = out_ready;
                pd = {out_last, out_row_last, out_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push_tile(input logic [9:0] b, input logic [7:0] wpr, rows, input logic [9:0] s);
        for (int r = 0; r < int'(rows); r++)
            for (int w = 0; w < int'(wpr); w++) begin
                logic [9:0] a;
                a = 10'((int'(b) + r * int'(s) + w * 4) & 1023);
                sb.push_back('{word_of(a), w == int'(wpr) - 1,
                               w == int'(wpr) - 1 && r == int'(rows) - 1});
            end
    endtask

    task automatic kick(input logic [9:0] b, input logic [7:0] wpr, rows, input logic [9:0] s);
        push_tile(b, wpr, rows, s);
        @(posedge clk); #1;
        base_addr = b; words_per_row = wpr; num_rows = rows; row_stride = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_d);
        int cyc = 0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", done, 1);
        if (done && exp_d >= 0) chk("done_cycle", cyc, exp_d);
        chk("sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        chk("done_pulse_width", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic wait_valid();
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("valid_seen", out_valid, 1);
    endtask

    task automatic run_tile(input vec_t v);
        logic [9:0] a0 = ram_addr;
        int n = int'(v.wpr) * int'(v.rows);
        kick(v.base, v.wpr, v.rows, v.stride);
        chk("busy_at_start", busy, n != 0);
        chk("addr_at_start", ram_addr, n != 0 ? v.base : a0);
        wait_done(v.exp_done);
        if (n == 0) begin
            chk("addr_unchanged", ram_addr, a0);
            chk("no_valid_empty", out_valid, 0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_data"}, {out_last, out_row_last, out_data}, 0);
        chk({tag, "_ram_wr"}, {ram_we, ram_d}, 0);
    endtask

    initial begin
        vecs[0] = '{10'h010, 8'd2, 8'd2, 10'h020, 6};
        vecs[1] = '{10'h3F8, 8'd4, 8'd1, 10'h000, 6};
        vecs[2] = '{10'h100, 8'd0, 8'd3, 10'h010, 0};
        vecs[3] = '{10'h200, 8'd3, 8'd0, 10'h010, 0};
        vecs[4] = '{10'h040, 8'd1, 8'd3, 10'h010, 5};
        vecs[5] = '{10'h3F0, 8'd3, 8'd3, 10'h3F8, 11};
        vecs[6] = '{10'h000, 8'd1, 8'd1, 10'h000, 3};
        resetn = 1'b0; start = 1'b0; out_ready = 1'b1;
        base_addr = '0; words_per_row = '0; num_rows = '0; row_stride = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) run_tile(vecs[i]);

        // Backpressure on the small tile, then a longer tile that must stall on credits.
        out_ready = 1'b0;
        kick(10'h010, 8'd2, 8'd2, 10'h020);
        wait_valid();
        repeat (6) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        wait_done(-1);
        out_ready = 1'b0;
        kick(10'h080, 8'd8, 8'd1, 10'h000);
        wait_valid();
        repeat (6) begin @(posedge clk); #1; end
        chk("credit_stall_addr", ram_addr, 10'h08C);
        chk("credit_stall_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_done(-1);

        // Reset in mid-READ abandons the transfer silently.
        kick(10'h010, 8'd8, 8'd1, 10'h000);
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_before_reset", busy, 1);
        resetn = 1'b0;
        #1;
        check_zero_outputs("midreset");
        sb.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_done_after_reset", done, 0);
            chk("idle_after_reset", busy, 0);
        end

        // Clean transfer after reset; a start pulse while busy is ignored.
        kick(10'h200, 8'd2, 8'd3, 10'h040);
        repeat (2) begin @(posedge clk); #1; end
        base_addr = 10'h300; words_per_row = 8'd5; num_rows = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(-1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("ignored_start_valid", out_valid, 0);
            chk("ignored_start_busy", busy, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
